// File: rtl/fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : fibonacci_checker
// Description : Checks a streamed word sequence against the Fibonacci
//               recurrence modulo 2^DATA_WIDTH. FIB_CHECK_RESYNC_EN selects
//               resynchronise-on-mismatch instead of a sticky FAIL state.
// Revision    : 1.0 - initial release
// ============================================================================
module fibonacci_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    output logic                  match,
    output logic                  error,
    output logic [CNT_WIDTH-1:0]  term_count
);

    localparam logic [1:0] S_SEED0 = 2'd0;
    localparam logic [1:0] S_SEED1 = 2'd1;
    localparam logic [1:0] S_TRACK = 2'd2;
    localparam logic [1:0] S_FAIL  = 2'd3;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
`ifdef FIB_CHECK_RESYNC_EN
    localparam logic [CNT_WIDTH-1:0] c_cnt_two = c_cnt_one + c_cnt_one;
`endif

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_prev;
    logic [DATA_WIDTH-1:0] r_cur;
    logic [CNT_WIDTH-1:0]  r_count;
    logic                  r_match;
    logic                  r_error;

    logic                  w_accept;
    logic                  w_track_accept;
    logic                  w_equal;
    logic [DATA_WIDTH-1:0] w_expected;
    logic [CNT_WIDTH-1:0]  w_count_inc;

    assign in_ready       = !clear && (r_state != S_FAIL);
    assign w_accept       = in_valid && in_ready;
    assign w_track_accept = w_accept && (r_state == S_TRACK);
    // Carry out of the sum is dropped so the check wraps naturally.
    assign w_expected     = r_prev + r_cur;
    assign w_equal        = (in_data == w_expected);
    assign w_count_inc    = (r_count == c_cnt_max) ? r_count : r_count + c_cnt_one;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_SEED0;
            r_prev  <= '0;
            r_cur   <= '0;
            r_count <= '0;
            r_match <= 1'b0;
            r_error <= 1'b0;
        end else if (clear) begin
            r_state <= S_SEED0;
            r_prev  <= '0;
            r_cur   <= '0;
            r_count <= '0;
            r_match <= 1'b0;
            r_error <= 1'b0;
        end else begin
            r_match <= w_track_accept && w_equal;
`ifdef FIB_CHECK_RESYNC_EN
            r_error <= w_track_accept && !w_equal;
`else
            r_error <= r_error || (w_track_accept && !w_equal);
`endif
            if (w_accept) begin
                r_count <= w_count_inc;
                case (r_state)
                    S_SEED0: begin
                        r_prev  <= in_data;
                        r_state <= S_SEED1;
                    end
                    S_SEED1: begin
                        r_cur   <= in_data;
                        r_state <= S_TRACK;
                    end
                    S_TRACK: begin
                        if (w_equal) begin
                            r_prev <= r_cur;
                            r_cur  <= in_data;
                        end else begin
`ifdef FIB_CHECK_RESYNC_EN
                            // Treat the last two observed words as fresh seeds.
                            r_prev  <= r_cur;
                            r_cur   <= in_data;
                            r_count <= c_cnt_two;
`else
                            r_state <= S_FAIL;
`endif
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign match      = r_match;
    assign error      = r_error;
    assign term_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_fibonacci_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_fibonacci_checker
// Description : Directed self-checking bench for fibonacci_checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fibonacci_checker;

    logic        clk = 1'b0;
    logic        resetn;
    logic        clear;

    logic        in_valid_a;
    logic [31:0] in_data_a;
    logic        in_ready_a;
    logic        match_a;
    logic        error_a;
    logic [15:0] term_count_a;

    logic        in_valid_b;
    logic [7:0]  in_data_b;
    logic        in_ready_b;
    logic        match_b;
    logic        error_b;
    logic [2:0]  term_count_b;

    int checks = 0;
    int errors = 0;
    int n_match;

    int unsigned seq1[6] = '{1, 1, 2, 3, 5, 8};
    int unsigned exp1[6] = '{0, 0, 1, 1, 1, 1};
    int unsigned seq2[4] = '{1, 2, 3, 5};
    int unsigned exp2[4] = '{0, 0, 1, 1};
    int unsigned seq8[8] = '{89, 144, 233, 121, 98, 219, 61, 24};
    int unsigned exp8m[8] = '{0, 0, 1, 1, 1, 1, 1, 1};
    int unsigned exp8c[8] = '{1, 2, 3, 4, 5, 6, 7, 7};

    always #5 clk = ~clk;

    fibonacci_checker u_dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .in_valid   (in_valid_a),
        .in_data    (in_data_a),
        .in_ready   (in_ready_a),
        .match      (match_a),
        .error      (error_a),
        .term_count (term_count_a)
    );

    fibonacci_checker #(.DATA_WIDTH(8), .CNT_WIDTH(3)) u_dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (clear),
        .in_valid   (in_valid_b),
        .in_data    (in_data_b),
        .in_ready   (in_ready_b),
        .match      (match_b),
        .error      (error_b),
        .term_count (term_count_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_a(input logic [31:0] d);
        in_valid_a = 1'b1;
        in_data_a  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int n);
        in_valid_a = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            chk("idle_no_match", match_a, 0);
        end
    endtask

    task automatic send_b(input logic [7:0] d);
        in_valid_b = 1'b1;
        in_data_b  = d;
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        in_valid_a = 1'b0;
        clear = 1'b1;
        #1;
        chk("clear_ready_low", in_ready_a, 0);
        @(posedge clk);
        #1;
        clear = 1'b0;
        #1;
        chk("clear_count", term_count_a, 0);
        chk("clear_error", error_a, 0);
        chk("clear_ready_high", in_ready_a, 1);
    endtask

    initial begin
        resetn     = 1'b0;
        clear      = 1'b0;
        in_valid_a = 1'b0;
        in_data_a  = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;
        #12;
        chk("reset_match", match_a, 0);
        chk("reset_error", error_a, 0);
        chk("reset_count", term_count_a, 0);
        chk("reset_ready", in_ready_a, 1);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back 1,1,2,3,5,8
        n_match = 0;
        for (int i = 0; i < 6; i++) begin
            send_a(seq1[i]);
            chk("b2b_match", match_a, exp1[i]);
            n_match += int'(match_a);
        end
        idle_a(1);
        chk("b2b_match_total", n_match, 4);
        chk("b2b_error", error_a, 0);
        chk("b2b_count", term_count_a, 6);

        // 1,2,3,5 with random gaps
        do_clear();
        n_match = 0;
        for (int i = 0; i < 4; i++) begin
            send_a(seq2[i]);
            chk("gap_match", match_a, exp2[i]);
            n_match += int'(match_a);
            idle_a(int'($urandom_range(0, 3)));
        end
        chk("gap_match_total", n_match, 2);
        chk("gap_count", term_count_a, 4);

`ifndef FIB_CHECK_RESYNC_EN
        // Sticky failure on 1,1,2,4
        do_clear();
        send_a(1);
        send_a(1);
        send_a(2);
        chk("fail_pre_match", match_a, 1);
        send_a(4);
        in_valid_a = 1'b0;
        chk("fail_match", match_a, 0);
        chk("fail_error", error_a, 1);
        chk("fail_ready", in_ready_a, 0);
        chk("fail_count", term_count_a, 4);
        idle_a(3);
        chk("fail_error_held", error_a, 1);
        send_a(6);
        send_a(6);
        in_valid_a = 1'b0;
        chk("fail_no_accept_count", term_count_a, 4);
        chk("fail_no_accept_match", match_a, 0);
        chk("fail_error_held2", error_a, 1);
        do_clear();
        send_a(10);
        send_a(20);
        chk("post_clear_seed_match", match_a, 0);
        chk("post_clear_count", term_count_a, 2);
        send_a(30);
        chk("post_clear_track_match", match_a, 1);
`else
        // Resync on 1,1,2,4,6,10
        do_clear();
        send_a(1);
        send_a(1);
        send_a(2);
        send_a(4);
        chk("resync_error_pulse", error_a, 1);
        chk("resync_match_on_err", match_a, 0);
        chk("resync_count_restart", term_count_a, 2);
        chk("resync_ready", in_ready_a, 1);
        send_a(6);
        chk("resync_error_drop", error_a, 0);
        chk("resync_match6", match_a, 1);
        send_a(10);
        chk("resync_match10", match_a, 1);
        chk("resync_count", term_count_a, 4);
        idle_a(1);
        chk("resync_error_idle", error_a, 0);
`endif

        // Asynchronous reset mid-TRACK
        do_clear();
        send_a(1);
        send_a(1);
        send_a(2);
        chk("areset_pre_match", match_a, 1);
        in_valid_a = 1'b1;
        in_data_a  = 3;
        #2;
        resetn = 1'b0;
        #1;
        chk("areset_match", match_a, 0);
        chk("areset_error", error_a, 0);
        chk("areset_count", term_count_a, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("areset_seed0_match", match_a, 0);
        chk("areset_seed0_count", term_count_a, 1);
        send_a(4);
        chk("areset_seed1_match", match_a, 0);
        send_a(7);
        chk("areset_track_match", match_a, 1);
        chk("areset_track_count", term_count_a, 3);

        // clear wins over a concurrent valid word
        clear      = 1'b1;
        in_valid_a = 1'b1;
        in_data_a  = 11;
        @(posedge clk);
        #1;
        chk("clear_prio_count", term_count_a, 0);
        chk("clear_prio_match", match_a, 0);
        clear      = 1'b0;
        in_valid_a = 1'b0;
        #1;
        chk("clear_prio_ready", in_ready_a, 1);

        // 8-bit wrap-around and 3-bit counter saturation
        for (int i = 0; i < 8; i++) begin
            send_b(seq8[i][7:0]);
            chk("w8_match", match_b, exp8m[i]);
            chk("w8_count", term_count_b, exp8c[i]);
        end
        in_valid_b = 1'b0;
        chk("w8_error", error_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fibonacci_checker.md
FIBONACCI_CHECKER -- requirements
Module: fibonacci_checker

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of checked words.
REQ-002 Parameter CNT_WIDTH, default 16: width of term_count.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 clear  input  1  synchronous restart of checking, active-high.
REQ-006 in_valid  input  1  in_data holds a word to be checked.
REQ-007 in_data  input  DATA_WIDTH  candidate sequence word.
REQ-008 in_ready  output  1  checker accepts a word this cycle.
REQ-009 match  output  1  one-cycle pulse: last accepted tracked word equalled its expected value.
REQ-010 error  output  1  mismatch indication; sticky or pulse per REQ-027/028.
REQ-011 term_count  output  CNT_WIDTH  words accepted in the current run, seeds included.

Function
REQ-012 A word SHALL be accepted only in a cycle with in_valid=1 and in_ready=1 at the rising edge.
REQ-013 in_ready SHALL be combinational: 1 when clear=0 and state is not FAIL, else 0.
REQ-014 States: SEED0, SEED1, TRACK, FAIL.
REQ-015 SEED0: accepted word loads prev register; go to SEED1; no match, no error.
REQ-016 SEED1: accepted word loads cur register; go to TRACK; no match, no error.
REQ-017 TRACK: expected = (prev + cur) mod 2^DATA_WIDTH, carry discarded.
REQ-018 TRACK, accepted word == expected: prev<=cur, cur<=word, match pulses high the following cycle.
REQ-019 TRACK, accepted word != expected: match stays 0; error behaviour per Configuration.
REQ-020 No accepted word in a cycle: state, prev, cur, term_count unchanged; match 0.
REQ-021 term_count SHALL increment by 1 per accepted word and saturate at 2^CNT_WIDTH-1.
REQ-022 match and error pulses SHALL be registered outputs, latency exactly one cycle after acceptance.
REQ-023 clear=1 SHALL, at the next edge, force SEED0, prev=cur=0, term_count=0, match=0, error=0; clear has priority over any concurrent in_valid (no word accepted, in_ready=0).
REQ-024 Wrap-around: sequence continuing past 2^DATA_WIDTH SHALL be checked modulo 2^DATA_WIDTH without error.

Reset
REQ-025 resetn=0 SHALL immediately, regardless of clk, force state SEED0, prev=0, cur=0, term_count=0, match=0, error=0; in_ready follows REQ-013.
REQ-026 Reset asserted mid-run SHALL discard all history; first word after deassertion is treated as seed 0.

Configuration
REQ-027 Macro FIB_CHECK_RESYNC_EN undefined: a mismatch SHALL move to FAIL, set error=1 sticky until clear or reset, drop in_ready, hold term_count; the mismatching word counts as accepted.
REQ-028 Macro FIB_CHECK_RESYNC_EN defined: FAIL state SHALL be unreachable; a mismatch pulses error for one cycle, loads prev<=cur, cur<=word, restarts term_count at 2, stays in TRACK with in_ready high.

Verification
REQ-029 Reset, then feed 1,1,2,3,5,8 back-to-back -> match pulses on cycles after 2,3,5,8 (4 pulses), error=0, term_count=6.
REQ-030 Feed 1,2,3,5 with in_valid gaps of 0-3 random cycles -> same match count 2, no spurious pulses during gaps, term_count=4.
REQ-031 Macro undefined: feed 1,1,2,4 -> error=1 one cycle after 4 and held, in_ready=0, term_count=4; pulse clear -> error=0, state SEED0, in_ready=1.
REQ-032 Macro defined: feed 1,1,2,4,6,10 -> error pulses once after 4, match after 6 and 10, term_count=4.
REQ-033 DATA_WIDTH=8: feed 89,144,233,121 (377 mod 256) -> match after 233 and 121, error=0.
REQ-034 Assert resetn=0 asynchronously between edges mid-TRACK with in_valid=1 -> all outputs 0 immediately, next accepted word seeds SEED0; clear and in_valid high same cycle -> word not accepted, term_count=0.
